n64_vdemux: RTL

Demultiplexes the N64 VI's 7-bit time-multiplexed video bus into parallel sync and RGB words. One group is four VCLK cycles: sync, R, G, B. The block tracks the group phase from nDSYNC and publishes a current/previous pixel pair. It also provides the Sync_pre/Sync_cur nibbles and a one-cycle nVDSYNC marker consumed directly by n64_vinfo_ext, and it reports bus lock status.

---
 rtl/n64_vdemux_pkg.sv | 21 ++
 rtl/n64_vdemux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/n64_vdemux_pkg.sv
// rtl/n64_vdemux_pkg.sv - shared widths, FSM encoding and helpers for the N64 video demux
package n64_vdemux_pkg;

    localparam int color_width_i = 7;
    localparam int sync_width    = 4;
    localparam int vdata_width   = 25;

    // Group phase: WAIT idles until a sync slot, then R, G, B slots follow
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_GET_R = 2'd1,
        ST_GET_G = 2'd2,
        ST_GET_B = 2'd3
    } vdemux_state_e;

    // Error counter increment that sticks at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/n64_vdemux.sv
// rtl/n64_vdemux.sv - N64 VI 7-bit multiplexed bus to parallel sync/RGB demux
module n64_vdemux
    import n64_vdemux_pkg::*;
#(
    parameter int unsigned LOCK_GROUPS = 4
) (
    input  logic                     VCLK,
    input  logic                     RST,
    input  logic                     nDSYNC,
    input  logic [color_width_i-1:0] D_i,
    output logic [vdata_width-1:0]   vdata_cur_o,
    output logic [vdata_width-1:0]   vdata_pre_o,
    output logic [sync_width-1:0]    Sync_cur,
    output logic [sync_width-1:0]    Sync_pre,
    output logic                     nVDSYNC_o,
    output logic                     lock_o,
    output logic [7:0]               err_cnt_o
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_GROUPS);

    // Input stage
    logic [color_width_i-1:0] d_q;
    logic                     nd_q;

    // Decoder state
    vdemux_state_e            state_q,  state_d;
    logic [sync_width-1:0]    sync_q,   sync_d;
    logic [color_width_i-1:0] r_q,      r_d;
    logic [color_width_i-1:0] g_q,      g_d;
    logic [vdata_width-1:0]   cur_q,    cur_d;
    logic [vdata_width-1:0]   pre_q,    pre_d;
    logic                     nvd_q,    nvd_d;
    logic [3:0]               lock_cnt_q, lock_cnt_d;
    logic                     lock_q,   lock_d;
    logic [7:0]               err_q,    err_d;
    // Set while the previous cycle was already a sync-less WAIT cycle, so a
    // long idle run is counted once. Reset sets it so a post-reset idle bus
    // is not reported as a missing sync.
    logic                     miss_seen_q, miss_seen_d;

    logic                     publish;
    logic                     short_grp;
    logic                     miss_sync;
    logic                     malformed;

    // Register the raw pins; all decoding works on these copies
    always_ff @(posedge VCLK) begin
        if (RST) begin
            d_q  <= '0;
            nd_q <= 1'b1;
        end else begin
            d_q  <= D_i;
            nd_q <= nDSYNC;
        end
    end

    // Group-phase FSM, slot capture, publish and error/lock bookkeeping
    always_comb begin
        state_d     = state_q;
        sync_d      = sync_q;
        r_d         = r_q;
        g_d         = g_q;
        cur_d       = cur_q;
        pre_d       = pre_q;
        nvd_d       = 1'b1;
        miss_seen_d = 1'b0;
        publish     = 1'b0;
        short_grp   = 1'b0;
        miss_sync   = 1'b0;

        if (!nd_q) begin
            // A sync slot always starts a new group; mid-group it also
            // discards the partial group in the same cycle.
            state_d   = ST_GET_R;
            sync_d    = d_q[sync_width-1:0];
            short_grp = (state_q != ST_WAIT);
        end else begin
            case (state_q)
                ST_WAIT: begin
                    miss_sync   = !miss_seen_q;
                    miss_seen_d = 1'b1;
                end
                ST_GET_R: begin
                    r_d     = d_q;
                    state_d = ST_GET_G;
                end
                ST_GET_G: begin
                    g_d     = d_q;
                    state_d = ST_GET_B;
                end
                ST_GET_B: begin
                    publish = 1'b1;
                    pre_d   = cur_q;
                    cur_d   = {sync_q, r_q, g_q, d_q};
                    nvd_d   = 1'b0;
                    state_d = ST_WAIT;
                end
                default: state_d = ST_WAIT;
            endcase
        end

        malformed = short_grp | miss_sync;
        err_d     = malformed ? sat_inc8(err_q) : err_q;

        if (malformed) begin
            lock_cnt_d = 4'd0;
        end else if (publish && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end

        // Lock follows the counter one edge late, but a malformed event
        // drops it immediately alongside the counter clear.
        lock_d = malformed ? 1'b0 : (lock_cnt_q == LOCK_MAX);
    end

    // Decoder state registers
    always_ff @(posedge VCLK) begin
        if (RST) begin
            state_q     <= ST_WAIT;
            sync_q      <= '0;
            r_q         <= '0;
            g_q         <= '0;
            cur_q       <= '0;
            pre_q       <= '0;
            nvd_q       <= 1'b1;
            lock_cnt_q  <= 4'd0;
            lock_q      <= 1'b0;
            err_q       <= 8'd0;
            miss_seen_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            r_q         <= r_d;
            g_q         <= g_d;
            cur_q       <= cur_d;
            pre_q       <= pre_d;
            nvd_q       <= nvd_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            miss_seen_q <= miss_seen_d;
        end
    end

    assign vdata_cur_o = cur_q;
    assign vdata_pre_o = pre_q;
    assign Sync_cur    = cur_q[vdata_width-1 -: sync_width];
    assign Sync_pre    = pre_q[vdata_width-1 -: sync_width];
    assign nVDSYNC_o   = nvd_q;
    assign lock_o      = lock_q;
    assign err_cnt_o   = err_q;

endmodule
